// File: rtl/conv_acc_top.sv
// conv_acc_top: multi-channel valid-mode 2-D convolution accumulator.
// Pixels stream in row-major order, one channel at a time, CO passes of CI
// channels each. Every accepted pixel is scattered into all M*M partial sums
// it contributes to. The result for (oh,ow) is emitted the cycle after its
// last contributing pixel of the final channel arrives.
// Optional build macro: CONV_ACC_RELU_EN clamps negative results to zero.
module conv_acc_top #(
   parameter int DATA_WIDTH   = 32,
   parameter int WEIGHT_WIDTH = 8,
   parameter int IFM_WIDTH    = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int IFM_SIZE     = 8,
   parameter int FIFO_SIZE    = IFM_SIZE - KERNEL_SIZE + 1,
   parameter int CI           = 2,
   parameter int CO           = 2
) (
   input  logic                                            clk1,
   input  logic                                            rst_n,
   input  logic                                            start_conv,
   input  logic                                            set_ifm,
   input  logic                                            set_wgt,
   input  logic [IFM_WIDTH-1:0]                            ifm,
   input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt,
   output logic                                            out_valid,
   output logic                                            end_conv,
   output logic [DATA_WIDTH-1:0]                           data_output
);

   localparam int K  = KERNEL_SIZE;
   localparam int N  = IFM_SIZE;
   localparam int M  = FIFO_SIZE;
   localparam int WW = WEIGHT_WIDTH * K * K;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = (CI > 1) ? $clog2(CI) : 1;
   localparam int PW = (CO > 1) ? $clog2(CO) : 1;

   localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
   localparam logic [HW-1:0] CH_LAST = HW'(CI - 1);
   localparam logic [PW-1:0] PS_LAST = PW'(CO - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           col, row;
   logic [HW-1:0]           ch;
   logic [PW-1:0]           pass;
   logic                    gap_pend;
   logic                    accept, gap_take;
   logic                    first_pix, last_pix_ch, out_hit, last_all, clear_pass;
   logic [WW-1:0]           wgt_q, eff_w;
   logic [DATA_WIDTH-1:0]   acc     [M*M];
   logic [DATA_WIDTH-1:0]   acc_nxt [M*M];
   logic [DATA_WIDTH-1:0]   out_sum;
   int                      row_i, col_i;

   // Sign-extend both operands to the accumulator width; the product wraps.
   function automatic logic [DATA_WIDTH-1:0] mul_ext(input logic [IFM_WIDTH-1:0] p,
                                                     input logic [WEIGHT_WIDTH-1:0] w);
      logic signed [DATA_WIDTH-1:0] pe, we;
      pe = DATA_WIDTH'($signed(p));
      we = DATA_WIDTH'($signed(w));
      return pe * we;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] relu_clamp(input logic [DATA_WIDTH-1:0] v);
`ifdef CONV_ACC_RELU_EN
      return v[DATA_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign row_i       = int'(row);
   assign col_i       = int'(col);
   assign first_pix   = (row == '0) && (col == '0);
   assign last_pix_ch = (row == N_LAST) && (col == N_LAST);
   assign out_hit     = (ch == CH_LAST) && (row >= K_LAST) && (col >= K_LAST);
   assign last_all    = accept && last_pix_ch && (ch == CH_LAST) && (pass == PS_LAST);
   assign clear_pass  = accept && last_pix_ch && (ch == CH_LAST);
   // The first pixel of a channel must already use the kernel arriving with it.
   assign eff_w       = (first_pix && set_wgt) ? wgt : wgt_q;

   // State register.
   always_ff @(posedge clk1) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle handshake decode; start_conv outranks set_ifm.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      gap_take  = 1'b0;
      case (state)
         IDLE: if (start_conv) state_nxt = LOAD;
         LOAD: begin
            if (start_conv) begin
               state_nxt = LOAD;
            end else if (set_ifm) begin
               gap_take = gap_pend;
               accept   = !gap_pend;
               if (last_all) state_nxt = DONE;
            end
         end
         DONE: state_nxt = start_conv ? LOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Column/row/channel/pass counters and the pending row-gap flag.
   always_ff @(posedge clk1) begin
      if (rst_n || start_conv) begin
         col      <= '0;
         row      <= '0;
         ch       <= '0;
         pass     <= '0;
         gap_pend <= 1'b0;
      end else if (gap_take) begin
         gap_pend <= 1'b0;
      end else if (accept) begin
         if (col == N_LAST) begin
            col      <= '0;
            gap_pend <= 1'b1;
            if (row == N_LAST) begin
               row <= '0;
               if (ch == CH_LAST) begin
                  ch   <= '0;
                  pass <= (pass == PS_LAST) ? '0 : pass + 1'b1;
               end else begin
                  ch <= ch + 1'b1;
               end
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Kernel is captured once per channel and held for the rest of it.
   always_ff @(posedge clk1) begin
      if (accept && first_pix && set_wgt) wgt_q <= wgt;
   end

   // Scatter the accepted pixel into every partial sum whose window covers it.
   always_comb begin
      acc_nxt = acc;
      out_sum = '0;
      if (accept) begin
         for (int oh = 0; oh < M; oh++) begin
            for (int ow = 0; ow < M; ow++) begin
               if (row_i >= oh && row_i < oh + K && col_i >= ow && col_i < ow + K) begin
                  acc_nxt[oh*M+ow] = acc[oh*M+ow] + mul_ext(ifm,
                     eff_w[((row_i-oh)*K + (col_i-ow))*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                  if (oh == row_i - (K-1) && ow == col_i - (K-1)) out_sum = acc_nxt[oh*M+ow];
               end
            end
         end
         if (clear_pass) begin
            for (int i = 0; i < M*M; i++) acc_nxt[i] = '0;
         end
      end
   end

   // Partial-sum buffer; emptied on reset, restart and at each pass boundary.
   always_ff @(posedge clk1) begin
      if (rst_n || start_conv) begin
         for (int i = 0; i < M*M; i++) acc[i] <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

   // Result register: data_output holds between valid results.
   always_ff @(posedge clk1) begin
      if (rst_n) begin
         out_valid   <= 1'b0;
         end_conv    <= 1'b0;
         data_output <= '0;
      end else begin
         out_valid <= accept && out_hit;
         end_conv  <= (state == DONE);
         if (accept && out_hit) data_output <= relu_clamp(out_sum);
      end
   end

endmodule

// File: tb/tb_conv_acc_top.sv
// Randomized self-checking bench for conv_acc_top with a direct
// sum-of-products reference model of the convolution.
module tb_conv_acc_top;

   localparam int K  = 3;
   localparam int N  = 8;
   localparam int M  = N - K + 1;
   localparam int CI = 2;
   localparam int CO = 2;
   localparam int DW = 32;
   localparam int WW = 8 * K * K;

   logic          clk1 = 1'b0;
   logic          rst_n = 1'b1;
   logic          start_conv = 1'b0;
   logic          set_ifm = 1'b0;
   logic          set_wgt = 1'b0;
   logic [7:0]    ifm = '0;
   logic [WW-1:0] wgt = '0;
   logic          out_valid;
   logic          end_conv;
   logic [DW-1:0] data_output;

   conv_acc_top dut (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .start_conv  (start_conv),
      .set_ifm     (set_ifm),
      .set_wgt     (set_wgt),
      .ifm         (ifm),
      .wgt         (wgt),
      .out_valid   (out_valid),
      .end_conv    (end_conv),
      .data_output (data_output)
   );

   always #5 clk1 = ~clk1;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   int pix [CO][CI][N][N];
   int wt  [CO][CI][K][K];

   logic signed [DW-1:0] exp_q[$];
   logic signed [DW-1:0] got_q[$];
   int                   got_t[$];
   int                   exp_t[$];
   int                   n_end = 0;
   int                   end_t = 0;
   int                   hold_err = 0;
   logic [DW-1:0]        last_out = '0;

   always @(posedge clk1) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk1) begin
      if (out_valid) begin
         got_q.push_back($signed(data_output));
         got_t.push_back(cyc);
      end else if (data_output !== last_out) begin
         hold_err++;
      end
      if (end_conv) begin
         n_end++;
         end_t = cyc;
      end
      last_out = data_output;
   end

   task automatic chk(input string tag, input longint got, input longint expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic logic [WW-1:0] pack_w(input int co, input int ci);
      logic [WW-1:0] v;
      int t;
      v = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) begin
            t = wt[co][ci][r][c];
            v[(r*K+c)*8 +: 8] = t[7:0];
         end
      return v;
   endfunction

   // mode 0 ones, 1 ramp/centre tap, 2 ifm 3 w -1, 3 zeros, 4 random
   task automatic fill(input int mode);
      for (int co = 0; co < CO; co++)
         for (int ci = 0; ci < CI; ci++) begin
            for (int y = 0; y < N; y++)
               for (int x = 0; x < N; x++)
                  case (mode)
                     0: pix[co][ci][y][x] = 1;
                     1: pix[co][ci][y][x] = x;
                     2: pix[co][ci][y][x] = 3;
                     3: pix[co][ci][y][x] = 0;
                     default: pix[co][ci][y][x] = int'($urandom_range(0, 255)) - 128;
                  endcase
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  case (mode)
                     0: wt[co][ci][r][c] = 1;
                     1: wt[co][ci][r][c] = (r == 1 && c == 1) ? 1 : 0;
                     2: wt[co][ci][r][c] = -1;
                     default: wt[co][ci][r][c] = int'($urandom_range(0, 255)) - 128;
                  endcase
         end
   endtask

   task automatic build_exp();
      longint s;
      logic signed [DW-1:0] e;
      exp_q.delete();
      for (int co = 0; co < CO; co++)
         for (int oh = 0; oh < M; oh++)
            for (int ow = 0; ow < M; ow++) begin
               s = 0;
               for (int ci = 0; ci < CI; ci++)
                  for (int r = 0; r < K; r++)
                     for (int c = 0; c < K; c++)
                        s += longint'(pix[co][ci][oh+r][ow+c]) * longint'(wt[co][ci][r][c]);
               e = s[DW-1:0];
`ifdef CONV_ACC_RELU_EN
               if (e < 0) e = '0;
`endif
               exp_q.push_back(e);
            end
   endtask

   // stall: 0 none, 1 random idle cycles, 2 one 5-cycle hole mid-row
   task automatic drive(input int stall, input int gapv, input int abort_after);
      int cnt = 0;
      int t;
      @(posedge clk1); #1;
      start_conv = 1'b1;
      set_ifm    = 1'b1;
      ifm        = 8'h55;
      @(posedge clk1); #1;
      start_conv = 1'b0;
      for (int co = 0; co < CO; co++)
         for (int ci = 0; ci < CI; ci++)
            for (int y = 0; y < N; y++)
               for (int x = 0; x < N; x++) begin
                  if (abort_after >= 0 && cnt == abort_after) begin
                     set_ifm = 1'b0;
                     return;
                  end
                  if ((stall == 1 && $urandom_range(0, 3) == 0) ||
                      (stall == 2 && co == 0 && ci == 0 && y == 2 && x == 3)) begin
                     repeat (stall == 2 ? 5 : int'($urandom_range(1, 3))) begin
                        set_ifm = 1'b0;
                        ifm     = 8'($urandom());
                        set_wgt = 1'($urandom());
                        @(posedge clk1); #1;
                     end
                  end
                  t       = pix[co][ci][y][x];
                  set_ifm = 1'b1;
                  ifm     = t[7:0];
                  if (y == 0 && x == 0) begin
                     set_wgt = 1'b1;
                     wgt     = pack_w(co, ci);
                  end else begin
                     set_wgt = 1'($urandom());
                     wgt     = WW'({$urandom(), $urandom(), $urandom()});
                  end
                  if (ci == CI-1 && y >= K-1 && x >= K-1) exp_t.push_back(cyc + 1);
                  @(posedge clk1); #1;
                  cnt++;
                  if (x == N-1) begin
                     set_ifm = 1'b1;
                     ifm     = (gapv >= 0) ? 8'(gapv) : 8'($urandom());
                     set_wgt = 1'($urandom());
                     @(posedge clk1); #1;
                  end
               end
      set_ifm = 1'b0;
      set_wgt = 1'b0;
   endtask

   task automatic clear_mon();
      got_q.delete();
      got_t.delete();
      exp_t.delete();
      n_end    = 0;
      hold_err = 0;
   endtask

   task automatic do_run(input int mode, input int stall, input string name);
      fill(mode);
      build_exp();
      clear_mon();
      drive(stall, (mode == 3) ? 127 : -1, -1);
      repeat (6) @(posedge clk1);
      #1;
      chk({name, ".count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) begin
            chk($sformatf("%s.val%0d", name, i), got_q[i], exp_q[i]);
            chk($sformatf("%s.time%0d", name, i), got_t[i], exp_t[i]);
         end
      chk({name, ".end_count"}, n_end, 1);
      if (got_t.size() > 0) chk({name, ".end_time"}, end_t, got_t[got_t.size()-1] + 1);
      chk({name, ".hold"}, hold_err, 0);
   endtask

   initial begin
      rst_n = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      rst_n = 1'b0;
      @(negedge clk1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.end_conv", end_conv, 0);
      chk("rst.data_output", data_output, 0);

      do_run(0, 0, "ones");
      do_run(1, 0, "ramp");
      do_run(2, 0, "neg");
      do_run(3, 0, "gap127");
      do_run(4, 1, "rand_stall_a");
      do_run(4, 1, "rand_stall_b");
      do_run(0, 2, "stall5");

      // Reset in the middle of a pass, then confirm the block stays quiet.
      fill(0);
      build_exp();
      clear_mon();
      drive(0, -1, 40);
      rst_n = 1'b1;
      @(posedge clk1); #1;
      rst_n = 1'b0;
      clear_mon();
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.data_output", data_output, 0);
      repeat (10) begin
         set_ifm = 1'b1;
         ifm     = 8'($urandom());
         @(posedge clk1); #1;
      end
      set_ifm = 1'b0;
      chk("midrst.quiet_out", got_q.size(), 0);
      chk("midrst.quiet_end", n_end, 0);
      do_run(0, 0, "restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
